// File: rtl/muldiv_sequencer_if.sv
// Handshake and data bundle between the EX stage and the iterative multiply/divide unit.
// The pipeline drives the master side; muldiv_sequencer sits on the slave side.
interface muldiv_sequencer_if #(
   parameter int unsigned XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            flush;
   logic            stall;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, funct3, op_a, op_b, flush,
      input  stall, busy, done, result
   );

   modport slave (
      input  start, funct3, op_a, op_b, flush,
      output stall, busy, done, result
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with a sign/special-case fix-up before the result registers.
module muldiv_sequencer #(
   parameter int unsigned XLEN = 32
) (
   input logic               clk,
   input logic               reset_n,
   muldiv_sequencer_if.slave bus
);
   localparam int unsigned CW = $clog2(XLEN) + 1;
   localparam int unsigned PW = 2 * XLEN;

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [2:0]      f3_q, f3_d;
   logic            sign_a_q, sign_a_d;
   logic            sign_b_q, sign_b_d;
   logic            b_zero_q, b_zero_d;
   logic [XLEN-1:0] a_raw_q, a_raw_d;
   // opnd holds the multiplicand or the divisor; hi/lo form the product or remainder/quotient.
   logic [XLEN-1:0] opnd_q, opnd_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            signed_a, signed_b;
   logic            a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_shift;
   logic            div_ge;
   logic [XLEN-1:0] div_sub;
   logic [PW-1:0]   prod, prod_fix;
   logic [XLEN-1:0] quo_fix, rem_fix;
   logic [XLEN-1:0] fix_value;

   // Operand signedness per funct3: MULH/DIV/REM both signed, MULHSU rs1 only.
   always_comb begin
      signed_a = 1'b0;
      signed_b = 1'b0;
      case (bus.funct3)
         3'b001, 3'b100, 3'b110: begin
            signed_a = 1'b1;
            signed_b = 1'b1;
         end
         3'b010:  signed_a = 1'b1;
         default: ;
      endcase
   end

   assign a_neg = signed_a & bus.op_a[XLEN-1];
   assign b_neg = signed_b & bus.op_b[XLEN-1];
   assign a_mag = a_neg ? XLEN'(0) - bus.op_a : bus.op_a;
   assign b_mag = b_neg ? XLEN'(0) - bus.op_b : bus.op_b;

   // One iteration of each algorithm.
   assign mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : XLEN'(0))};
   assign div_shift = {hi_q, lo_q[XLEN-1]};
   assign div_ge    = div_shift >= {1'b0, opnd_q};
   assign div_sub   = div_shift[XLEN-1:0] - opnd_q;

   // Sign correction and special cases applied in FIX.
   always_comb begin
      prod     = {hi_q, lo_q};
      prod_fix = (sign_a_q ^ sign_b_q) ? PW'(0) - prod : prod;
      quo_fix  = (sign_a_q ^ sign_b_q) ? XLEN'(0) - lo_q : lo_q;
      rem_fix  = sign_a_q ? XLEN'(0) - hi_q : hi_q;
      if (b_zero_q) begin
         quo_fix = '1;
         rem_fix = a_raw_q;
      end
      case (f3_q)
         3'b000:                 fix_value = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fix_value = prod_fix[PW-1:XLEN];
         3'b100, 3'b101:         fix_value = quo_fix;
         default:                fix_value = rem_fix;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      f3_d     = f3_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      b_zero_d = b_zero_q;
      a_raw_d  = a_raw_q;
      opnd_d   = opnd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      result_d = result_q;

      unique case (state_q)
         StIdle: begin
            if (bus.start && !bus.flush) begin
               state_d  = StCalc;
               count_d  = '0;
               f3_d     = bus.funct3;
               sign_a_d = a_neg;
               sign_b_d = b_neg;
               b_zero_d = (bus.op_b == '0);
               a_raw_d  = bus.op_a;
               hi_d     = '0;
               if (bus.funct3[2]) begin
                  opnd_d = b_mag;
                  lo_d   = a_mag;
               end else begin
                  opnd_d = a_mag;
                  lo_d   = b_mag;
               end
            end
         end
         StCalc: begin
            count_d = count_q + 1'b1;
            if (f3_q[2]) begin
               hi_d = div_ge ? div_sub : div_shift[XLEN-1:0];
               lo_d = {lo_q[XLEN-2:0], div_ge};
            end else begin
               hi_d = mul_sum[XLEN:1];
               lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
            end
            if (count_q == CW'(XLEN - 1)) begin
               state_d = StFix;
            end
         end
         StFix: begin
            result_d = fix_value;
            state_d  = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
      endcase

      // A killed EX slot abandons the op without touching the visible result.
      if (bus.flush) begin
         state_d  = StIdle;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         count_q  <= '0;
         f3_q     <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         b_zero_q <= 1'b0;
         a_raw_q  <= '0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         f3_q     <= f3_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         b_zero_q <= b_zero_d;
         a_raw_q  <= a_raw_d;
         opnd_q   <= opnd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         result_q <= result_d;
      end
   end

   // Stall is held low during reset so a pending start cannot freeze the pipe.
   assign bus.stall  = reset_n & (((state_q == StIdle) & bus.start & ~bus.flush) |
                                  (state_q == StCalc) | (state_q == StFix));
   assign bus.busy   = (state_q != StIdle);
   assign bus.done   = (state_q == StDone);
   assign bus.result = result_q;
endmodule
